// File: rtl/intr_ctrl_pkg.sv
// Shared constants, FSM state type and vector helper for the interrupt controller.
package intr_ctrl_pkg;

  localparam int unsigned IRQ_ADDR_W = 10;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_VEC_BASE = 10'h3F0;
  localparam int unsigned IRQ_VEC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Handler address before truncation to the PC width; the caller keeps the low bits,
  // which makes the vector arithmetic wrap modulo 2^ADDR_W.
  function automatic logic [31:0] vec_calc(input logic [31:0] base,
                                           input int unsigned step,
                                           input logic [2:0] idx);
    return base + 32'(idx) * step;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-side bundle of the interrupt controller: raw lines, mask write, handshake and status.
interface intr_ctrl_if #(
  parameter int unsigned NIRQ   = 2,
  parameter int unsigned ADDR_W = 10
);
  logic [NIRQ-1:0]   irq_raw;
  logic              en_we;
  logic [NIRQ-1:0]   en_din;
  logic              ack;
  logic              iret;
  logic              irq;
  logic [ADDR_W-1:0] irq_vec;
  logic [2:0]        irq_id;
  logic [NIRQ-1:0]   pending;
  logic [NIRQ-1:0]   enable;
  logic              busy;

  // CPU / system side
  modport master (
    output irq_raw, en_we, en_din, ack, iret,
    input  irq, irq_vec, irq_id, pending, enable, busy
  );

  // Controller side
  modport slave (
    input  irq_raw, en_we, en_din, ack, iret,
    output irq, irq_vec, irq_id, pending, enable, busy
  );
endinterface

// File: rtl/intr_ctrl_irq_sync_edge.sv
// Two-flop synchroniser for one raw interrupt line plus a history flop for rising-edge detect.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);
  logic s1, s2, s3;

  // Synchroniser chain and history flop, cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches synchronised rising edges as pending, masks them,
// picks the lowest-index candidate and runs a non-nesting IDLE/REQ/SERVICE handshake.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int unsigned        NIRQ     = 2,
  parameter int unsigned        ADDR_W   = IRQ_ADDR_W,
  parameter logic [ADDR_W-1:0]  VEC_BASE = ADDR_W'(IRQ_VEC_BASE),
  parameter int unsigned        VEC_STEP = IRQ_VEC_STEP
) (
  input logic       clk,
  input logic       reset,
  intr_ctrl_if.slave bus
);
  state_t state, state_n;

  logic [NIRQ-1:0]   rises;
  logic [NIRQ-1:0]   pending_r, enable_r, cand, clr;
  logic              win_found;
  logic [2:0]        winner;
  logic [ADDR_W-1:0] win_vec;
  logic              irq_r, irq_n, busy_r, busy_n, take;
  logic [2:0]        id_r, id_n;
  logic [ADDR_W-1:0] vec_r, vec_n;

  for (genvar g = 0; g < NIRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.irq_raw[g]),
      .rise  (rises[g])
    );
  end

  // Fixed priority: lowest pending-and-enabled index wins
  always_comb begin
    cand      = pending_r & enable_r;
    win_found = 1'b0;
    winner    = '0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (cand[i] && !win_found) begin
        win_found = 1'b1;
        winner    = 3'(i);
      end
    end
    win_vec = ADDR_W'(vec_calc(32'(VEC_BASE), VEC_STEP, winner));
  end

  // Next-state and registered-output logic; REQ holds id/vec frozen until ack
  always_comb begin
    state_n = state;
    irq_n   = irq_r;
    id_n    = id_r;
    vec_n   = vec_r;
    busy_n  = busy_r;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_n = REQ;
          irq_n   = 1'b1;
          id_n    = winner;
          vec_n   = win_vec;
        end
      end
      REQ: begin
        if (bus.ack) begin
          state_n = SERVICE;
          irq_n   = 1'b0;
          busy_n  = 1'b1;
          take    = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.iret) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Ack clears the serviced bit; a coincident new edge on that line re-sets it
  assign clr = take ? (NIRQ'(1) << id_r) : '0;

  // State, handshake outputs, pending and enable registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      irq_r     <= 1'b0;
      id_r      <= '0;
      vec_r     <= '0;
      busy_r    <= 1'b0;
      pending_r <= '0;
      enable_r  <= '0;
    end else begin
      state     <= state_n;
      irq_r     <= irq_n;
      id_r      <= id_n;
      vec_r     <= vec_n;
      busy_r    <= busy_n;
      pending_r <= (pending_r & ~clr) | rises;
      if (bus.en_we) enable_r <= bus.en_din;
    end
  end

  assign bus.irq     = irq_r;
  assign bus.irq_id  = id_r;
  assign bus.irq_vec = vec_r;
  assign bus.busy    = busy_r;
  assign bus.pending = pending_r;
  assign bus.enable  = enable_r;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with a scoreboard of expected requests (id, vector).
module tb_intr_ctrl;
  logic clk = 1'b0;
  logic reset;

  intr_ctrl_if #(.NIRQ(2), .ADDR_W(10)) bus ();

  intr_ctrl #(
    .NIRQ     (2),
    .ADDR_W   (10),
    .VEC_BASE (10'h3F0),
    .VEC_STEP (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] id;
    logic [9:0] vec;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_en(input logic [1:0] v);
    bus.en_we  = 1'b1;
    bus.en_din = v;
    tick();
    bus.en_we  = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic do_iret();
    bus.iret = 1'b1;
    tick();
    bus.iret = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0] id, input logic [9:0] vec);
    exp_t e;
    e.id  = id;
    e.vec = vec;
    sb.push_back(e);
  endtask

  // Wait (bounded) for irq, then compare id/vector against the scoreboard head
  task automatic expect_req(input string tag, input int budget);
    exp_t e;
    int   n = 0;
    while (bus.irq !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_irq"}, 32'(bus.irq), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_id"}, 32'(bus.irq_id), 32'(e.id));
      chk({tag, "_vec"}, 32'(bus.irq_vec), 32'(e.vec));
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.irq_raw = '0;
    bus.en_we   = 1'b0;
    bus.en_din  = '0;
    bus.ack     = 1'b0;
    bus.iret    = 1'b0;
    ticks(2);
    reset = 1'b0;
    tick();
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_enable", 32'(bus.enable), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_id", 32'(bus.irq_id), 32'd0);
    chk("rst_vec", 32'(bus.irq_vec), 32'd0);

    // 1: reset asserted while a request is outstanding
    set_en(2'b11);
    bus.irq_raw = 2'b01;
    push_exp(3'd0, 10'h3F0);
    expect_req("t1_req", 8);
    #2 reset = 1'b1;
    #1;
    chk("t1_irq", 32'(bus.irq), 32'd0);
    chk("t1_pending", 32'(bus.pending), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_enable", 32'(bus.enable), 32'd0);
    bus.irq_raw = 2'b00;
    tick();
    reset = 1'b0;
    set_en(2'b11);
    ticks(4);
    chk("t1_no_spurious_irq", 32'(bus.irq), 32'd0);
    chk("t1_no_spurious_pend", 32'(bus.pending), 32'd0);

    // 2: exact latency from raw rise to pending and irq
    bus.irq_raw = 2'b01;
    push_exp(3'd0, 10'h3F0);
    tick();
    chk("t2_pend_k", 32'(bus.pending), 32'd0);
    tick();
    chk("t2_pend_k1", 32'(bus.pending), 32'd0);
    tick();
    chk("t2_pend_k2", 32'(bus.pending), 32'd1);
    chk("t2_irq_k2", 32'(bus.irq), 32'd0);
    tick();
    expect_req("t2_req", 0);
    bus.irq_raw = 2'b00;
    do_ack();
    chk("t2_ack_irq", 32'(bus.irq), 32'd0);
    chk("t2_ack_busy", 32'(bus.busy), 32'd1);
    chk("t2_ack_pend", 32'(bus.pending), 32'd0);
    do_iret();
    chk("t2_iret_busy", 32'(bus.busy), 32'd0);

    // 3: simultaneous edges, priority and second vector
    ticks(3);
    bus.irq_raw = 2'b11;
    push_exp(3'd0, 10'h3F0);
    push_exp(3'd1, 10'h3F4);
    expect_req("t3_first", 8);
    do_ack();
    chk("t3_pend_after_ack", 32'(bus.pending), 32'd2);
    do_iret();
    chk("t3_gap_irq", 32'(bus.irq), 32'd0);
    expect_req("t3_second", 3);
    do_ack();
    do_iret();
    bus.irq_raw = 2'b00;

    // 4: masked pending bit requests once re-enabled
    set_en(2'b10);
    ticks(3);
    bus.irq_raw = 2'b01;
    ticks(4);
    bus.irq_raw = 2'b00;
    chk("t4_pend", 32'(bus.pending), 32'd1);
    chk("t4_masked_irq", 32'(bus.irq), 32'd0);
    push_exp(3'd0, 10'h3F0);
    set_en(2'b11);
    chk("t4_en", 32'(bus.enable), 32'd3);
    tick();
    expect_req("t4_req", 0);
    do_ack();
    do_iret();

    // 5: edge during SERVICE, spurious iret in REQ and ack in IDLE
    ticks(3);
    bus.irq_raw = 2'b01;
    push_exp(3'd0, 10'h3F0);
    expect_req("t5_first", 8);
    bus.irq_raw = 2'b00;
    do_ack();
    bus.irq_raw = 2'b10;
    push_exp(3'd1, 10'h3F4);
    ticks(4);
    chk("t5_svc_pend", 32'(bus.pending), 32'd2);
    chk("t5_svc_irq", 32'(bus.irq), 32'd0);
    chk("t5_svc_busy", 32'(bus.busy), 32'd1);
    do_iret();
    chk("t5_gap_irq", 32'(bus.irq), 32'd0);
    expect_req("t5_second", 3);
    do_iret();
    chk("t5_iret_in_req_irq", 32'(bus.irq), 32'd1);
    chk("t5_iret_in_req_busy", 32'(bus.busy), 32'd0);
    chk("t5_iret_in_req_id", 32'(bus.irq_id), 32'd1);
    do_ack();
    do_iret();
    bus.irq_raw = 2'b00;
    do_ack();
    chk("t5_ack_idle_irq", 32'(bus.irq), 32'd0);
    chk("t5_ack_idle_busy", 32'(bus.busy), 32'd0);
    chk("t5_ack_idle_pend", 32'(bus.pending), 32'd0);

    // 6: new line-0 edge lands in the same cycle as the ack of line 0
    ticks(3);
    bus.irq_raw = 2'b01;
    push_exp(3'd0, 10'h3F0);
    expect_req("t6_first", 8);
    bus.irq_raw = 2'b00;
    ticks(4);
    bus.irq_raw = 2'b01;
    tick();
    tick();
    do_ack();
    bus.irq_raw = 2'b00;
    chk("t6_ack_irq", 32'(bus.irq), 32'd0);
    chk("t6_ack_busy", 32'(bus.busy), 32'd1);
    chk("t6_pend_kept", 32'(bus.pending), 32'd1);
    push_exp(3'd0, 10'h3F0);
    do_iret();
    expect_req("t6_second", 3);
    do_ack();
    do_iret();
    chk("t6_pend_final", 32'(bus.pending), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
